// File: rtl/fft_fixed_point_pkg.sv
// Shared fixed-point definitions for the FFT datapath multiplier and divider.
// Also provides the divider state encoding and a magnitude helper.
package fft_fixed_point_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam logic [DATA_WIDTH-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DATA_WIDTH-1:0] Q_MIN = 16'h8000;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] DIV   = 2'd1;
  localparam logic [STATE_W-1:0] FINAL = 2'd2;

  // One extra bit so that |-32768| is representable.
  function automatic logic [DATA_WIDTH:0] abs_ext(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH:0] e;
    e = {x[DATA_WIDTH-1], x};
    return x[DATA_WIDTH-1] ? (~e + (DATA_WIDTH+1)'(1)) : e;
  endfunction

endpackage

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider: restoring division, one quotient bit per clock,
// saturating result truncated toward zero.
module fixed_point_divider
  import fft_fixed_point_pkg::*;
#(
  parameter int EXP_WIDTH_A        = 15,
  parameter int EXP_WIDTH_B        = 15,
  parameter int EXP_WIDTH_QUOTIENT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic                  done,
  output logic                  busy,
  output logic                  overflow,
  output logic                  div_by_zero
);

  localparam int          SHIFT = EXP_WIDTH_QUOTIENT + EXP_WIDTH_B - EXP_WIDTH_A;
  localparam int unsigned NUM_W = 32'(DATA_WIDTH + 1 + SHIFT);
  localparam int unsigned REM_W = DATA_WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(NUM_W);

  localparam logic [NUM_W-1:0] POS_LIM = NUM_W'(Q_MAX);
  localparam logic [NUM_W-1:0] NEG_LIM = NUM_W'(Q_MIN);

  if (SHIFT < 0) begin : g_shift_check
    $error("fixed_point_divider: quotient format needs a negative pre-shift");
  end

  logic [STATE_W-1:0]    state, state_nxt;
  logic [NUM_W-1:0]      num, num_nxt, q, q_nxt;
  logic [REM_W-1:0]      den, den_nxt, rem, rem_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  neg, neg_nxt, a_neg, a_neg_nxt, zero, zero_nxt;
  logic [DATA_WIDTH-1:0] quotient_nxt;
  logic                  done_nxt, busy_nxt, overflow_nxt, div_by_zero_nxt;
  logic [REM_W:0]        rem_sh;
  logic [REM_W-1:0]      rem_diff;

  // Next-state, datapath and output logic.
  always_comb begin
    state_nxt       = state;
    num_nxt         = num;
    q_nxt           = q;
    den_nxt         = den;
    rem_nxt         = rem;
    cnt_nxt         = cnt;
    neg_nxt         = neg;
    a_neg_nxt       = a_neg;
    zero_nxt        = zero;
    quotient_nxt    = quotient;
    done_nxt        = 1'b0;
    busy_nxt        = busy;
    overflow_nxt    = overflow;
    div_by_zero_nxt = div_by_zero;
    rem_sh          = {rem, num[NUM_W-1]};
    rem_diff        = REM_W'(rem_sh - {1'b0, den});

    case (state)
      IDLE: begin
        if (enable) begin
          num_nxt         = NUM_W'(abs_ext(A)) << SHIFT;
          den_nxt         = abs_ext(B);
          rem_nxt         = '0;
          q_nxt           = '0;
          neg_nxt         = A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1];
          a_neg_nxt       = A[DATA_WIDTH-1];
          zero_nxt        = (B == '0);
          cnt_nxt         = CNT_W'(NUM_W - 1);
          overflow_nxt    = 1'b0;
          div_by_zero_nxt = 1'b0;
          busy_nxt        = 1'b1;
          state_nxt       = DIV;
        end
      end
      DIV: begin
        // Zero-divisor operations still run the full count for fixed latency.
        num_nxt = num << 1;
        if (rem_sh >= {1'b0, den}) begin
          rem_nxt = rem_diff;
          q_nxt   = {q[NUM_W-2:0], 1'b1};
        end else begin
          rem_nxt = rem_sh[REM_W-1:0];
          q_nxt   = {q[NUM_W-2:0], 1'b0};
        end
        if (cnt == '0) state_nxt = FINAL;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      FINAL: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        if (zero) begin
          quotient_nxt    = a_neg ? Q_MIN : Q_MAX;
          div_by_zero_nxt = 1'b1;
        end else if (!neg) begin
          if (q > POS_LIM) begin
            quotient_nxt = Q_MAX;
            overflow_nxt = 1'b1;
          end else begin
            quotient_nxt = q[DATA_WIDTH-1:0];
          end
        end else begin
          // A magnitude of exactly 32768 negates to Q_MIN without saturating.
          if (q > NEG_LIM) begin
            quotient_nxt = Q_MIN;
            overflow_nxt = 1'b1;
          end else begin
            quotient_nxt = ~q[DATA_WIDTH-1:0] + DATA_WIDTH'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      num         <= '0;
      q           <= '0;
      den         <= '0;
      rem         <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
      a_neg       <= 1'b0;
      zero        <= 1'b0;
      quotient    <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      num         <= num_nxt;
      q           <= q_nxt;
      den         <= den_nxt;
      rem         <= rem_nxt;
      cnt         <= cnt_nxt;
      neg         <= neg_nxt;
      a_neg       <= a_neg_nxt;
      zero        <= zero_nxt;
      quotient    <= quotient_nxt;
      done        <= done_nxt;
      busy        <= busy_nxt;
      overflow    <= overflow_nxt;
      div_by_zero <= div_by_zero_nxt;
    end
  end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Scoreboard bench for fixed_point_divider (Q1.15 / Q1.15 -> Q1.15) against an arithmetic model.
module tb_fixed_point_divider;

  localparam int LAT = 33;

  logic        clk, reset, enable;
  logic [15:0] A, B, quotient;
  logic        done, busy, overflow, div_by_zero;

  typedef struct {
    logic [15:0] q;
    logic        ovf;
    logic        dbz;
    int          acc;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  fixed_point_divider dut (
    .clk(clk), .reset(reset), .enable(enable), .A(A), .B(B),
    .quotient(quotient), .done(done), .busy(busy),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: exact rational quotient from the signed values, truncated, then saturated.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int acc);
    exp_t   e;
    longint sa, sb, ma, mb, mag;
    bit     neg;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.acc = acc; e.a = a; e.b = b; e.ovf = 1'b0; e.dbz = 1'b0;
    if (sb == 0) begin
      e.dbz = 1'b1;
      e.q   = (sa < 0) ? 16'h8000 : 16'h7FFF;
      return e;
    end
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sb < 0) ? -sb : sb;
    mag = (ma * 32768) / mb;
    neg = (sa < 0) != (sb < 0);
    if (!neg) begin
      if (mag > 32767) begin e.q = 16'h7FFF; e.ovf = 1'b1; end
      else e.q = 16'(mag);
    end else begin
      if (mag > 32768) begin e.q = 16'h8000; e.ovf = 1'b1; end
      else e.q = 16'(-mag);
    end
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding request.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 required no pending result (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("quotient A=%h B=%h", e.a, e.b), 32'(quotient), 32'(e.q));
        check($sformatf("overflow A=%h B=%h", e.a, e.b), 32'(overflow), 32'(e.ovf));
        check($sformatf("div_by_zero A=%h B=%h", e.a, e.b), 32'(div_by_zero), 32'(e.dbz));
        check($sformatf("latency A=%h B=%h", e.a, e.b), 32'(cyc - e.acc), 32'(LAT));
      end
    end
  end

  // Called at posedge+1; waits for the divider to be free, then requests one division.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy=1 required 0 within 100 cycles");
      return;
    end
    A = a; B = b; enable = 1'b1;
    exp_q.push_back(model(a, b, cyc + 1));
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_quotient"}, 32'(quotient), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no completion required finish within 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [15:0] ra, rb;
    reset = 1'b0; enable = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed values, issued back-to-back in each done cycle.
    issue(16'h2000, 16'h4000);
    issue(16'hE000, 16'h4000);
    issue(16'h0001, 16'h0003);
    issue(16'hFFFF, 16'h0003);
    issue(16'h4000, 16'h2000);
    issue(16'h8000, 16'h7FFF);
    issue(16'h1000, 16'h0000);
    issue(16'hF000, 16'h0000);
    issue(16'h0000, 16'h1234);
    issue(16'h8000, 16'h8000);
    issue(16'h7FFF, 16'h8000);
    issue(16'hC000, 16'h4000);
    drain();

    // Enable pulsed mid-operation must be ignored.
    issue(16'h3000, 16'h6000);
    repeat (4) begin @(posedge clk); #1; end
    A = 16'h7FFF; B = 16'h0001; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0; A = '0; B = '0;
    check("busy_during_op", 32'(busy), 32'd1);
    drain();

    // Asynchronous reset in the middle of DIV discards the operation.
    issue(16'h1234, 16'h5678);
    repeat (10) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_reset_busy", 32'(busy), 32'd0);
    issue(16'h1234, 16'h5678);
    drain();

    // Randomized operands biased toward the interesting corners.
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 16'h0000;
        1: ra = 16'h8000;
        2: rb = 16'($urandom_range(1, 4));
        3: rb = 16'h8000;
        default: ;
      endcase
      issue(ra, rb);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
